// File: rtl/vmem_leak_scheduler_pkg.sv
// Shared definitions for the Vmem leak sweep controller.
//   - fixed-point Vmem geometry (Q<INTEGER_WIDTH>.<DATA_WIDTH_FRAC>)
//   - DeltaT and neuron-address widths
//   - sweep controller state encoding
package vmem_leak_scheduler_pkg;

  localparam int unsigned INTEGER_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH_FRAC   = 32;
  localparam int unsigned DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC;
  localparam int unsigned DELTAT_WIDTH      = 4;
  localparam int unsigned NEURON_ADDR_WIDTH = 11;

  typedef logic signed [DATA_WIDTH-1:0] vmem_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/vmem_leak_scheduler_if.sv
// Vmem memory port plus leak datapath operand bundle.
//   master : the sweep controller (issues reads/writes, drives leak operands)
//   slave  : memory arbiter / Vmem store / leak datapath side
// Signals:
//   RdGrant     shared read port available this cycle
//   VmemRdEn/VmemRdAddr/VmemRdData  read port, data valid 1 cycle after enable
//   VmemWrEn/VmemWrAddr/VmemWrData  write port
//   LeakVrest/LeakDeltaT/LeakTaumem latched leak operands
//   LeakVmemIn / LeakVmemOut        Vmem into / result out of the leak datapath
interface vmem_leak_scheduler_if #(
  parameter int unsigned INTEGER_WIDTH     = vmem_leak_scheduler_pkg::INTEGER_WIDTH,
  parameter int unsigned DATA_WIDTH        = vmem_leak_scheduler_pkg::DATA_WIDTH,
  parameter int unsigned DELTAT_WIDTH      = vmem_leak_scheduler_pkg::DELTAT_WIDTH,
  parameter int unsigned NEURON_ADDR_WIDTH = vmem_leak_scheduler_pkg::NEURON_ADDR_WIDTH
);

  logic                         RdGrant;
  logic                         VmemRdEn;
  logic [NEURON_ADDR_WIDTH-1:0] VmemRdAddr;
  logic [DATA_WIDTH-1:0]        VmemRdData;
  logic [INTEGER_WIDTH-1:0]     LeakVrest;
  logic [DELTAT_WIDTH-1:0]      LeakDeltaT;
  logic [INTEGER_WIDTH-1:0]     LeakTaumem;
  logic [DATA_WIDTH-1:0]        LeakVmemIn;
  logic [DATA_WIDTH-1:0]        LeakVmemOut;
  logic                         VmemWrEn;
  logic [NEURON_ADDR_WIDTH-1:0] VmemWrAddr;
  logic [DATA_WIDTH-1:0]        VmemWrData;

  modport master (
    input  RdGrant, VmemRdData, LeakVmemOut,
    output VmemRdEn, VmemRdAddr, LeakVrest, LeakDeltaT, LeakTaumem, LeakVmemIn,
           VmemWrEn, VmemWrAddr, VmemWrData
  );

  modport slave (
    output RdGrant, VmemRdData, LeakVmemOut,
    input  VmemRdEn, VmemRdAddr, LeakVrest, LeakDeltaT, LeakTaumem, LeakVmemIn,
           VmemWrEn, VmemWrAddr, VmemWrData
  );

endinterface

// File: rtl/vmem_leak_scheduler_leak_write_pipe.sv
// Two-stage valid/address/data path from a Vmem read to its write-back.
//   stage 1 : cycle after the read, read data is on the leak datapath;
//             result captured at the end of this cycle
//   stage 2 : write strobe with the registered leak result
// Ports:
//   Clock, Reset (async active-low)
//   rd_fire, rd_addr   read issued this cycle and its address
//   leak_result        combinational leak datapath output
//   s1_valid           stage-1 occupancy (read data on the bus this cycle)
//   wr_en, wr_addr, wr_data  write-back port
module vmem_leak_scheduler_leak_write_pipe #(
  parameter int unsigned DATA_WIDTH        = vmem_leak_scheduler_pkg::DATA_WIDTH,
  parameter int unsigned NEURON_ADDR_WIDTH = vmem_leak_scheduler_pkg::NEURON_ADDR_WIDTH
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         rd_fire,
  input  logic [NEURON_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]        leak_result,
  output logic                         s1_valid,
  output logic                         wr_en,
  output logic [NEURON_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]        wr_data
);

  logic [NEURON_ADDR_WIDTH-1:0] s1_addr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      s1_addr  <= rd_addr;
      wr_en    <= s1_valid;
      // Bubbles hold the last result; only the strobe carries meaning.
      if (s1_valid) begin
        wr_addr <= s1_addr;
        wr_data <= leak_result;
      end
    end
  end

endmodule

// File: rtl/vmem_leak_scheduler.sv
// Timestep leak sweep controller: reads every neuron's Vmem, routes it
// through the external combinational leak datapath and writes the
// registered result back, two cycles after each read.
// Ports:
//   Clock, Reset (async active-low)
//   Start        one-cycle pulse, accepted only when idle
//   NeuronCount  neurons to sweep (unsigned), latched at Start
//   Vrest, DeltaT, Taumem  leak operands, latched at Start
//   Busy         high from accepted Start until Done
//   Done         one-cycle pulse at sweep end
//   Error        sticky: Taumem was zero at Start; cleared by next Start
//   bus          memory port and leak datapath operands (master side)
module vmem_leak_scheduler
  import vmem_leak_scheduler_pkg::*;
#(
  parameter int unsigned INTEGER_WIDTH     = vmem_leak_scheduler_pkg::INTEGER_WIDTH,
  parameter int unsigned DATA_WIDTH_FRAC   = vmem_leak_scheduler_pkg::DATA_WIDTH_FRAC,
  parameter int unsigned DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int unsigned DELTAT_WIDTH      = vmem_leak_scheduler_pkg::DELTAT_WIDTH,
  parameter int unsigned NEURON_ADDR_WIDTH = vmem_leak_scheduler_pkg::NEURON_ADDR_WIDTH
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Start,
  input  logic [NEURON_ADDR_WIDTH-1:0]    NeuronCount,
  input  logic signed [INTEGER_WIDTH-1:0] Vrest,
  input  logic [DELTAT_WIDTH-1:0]         DeltaT,
  input  logic signed [INTEGER_WIDTH-1:0] Taumem,
  output logic                            Busy,
  output logic                            Done,
  output logic                            Error,
  vmem_leak_scheduler_if.master           bus
);

  state_t state_q, state_d;

  logic [NEURON_ADDR_WIDTH-1:0] count_q;
  logic [NEURON_ADDR_WIDTH-1:0] rd_idx_q;
  logic [INTEGER_WIDTH-1:0]     vrest_q;
  logic [INTEGER_WIDTH-1:0]     taumem_q;
  logic [DELTAT_WIDTH-1:0]      deltat_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         error_q;

  logic                         start_acc;
  logic                         rd_fire;
  logic                         last_rd;
  logic [NEURON_ADDR_WIDTH-1:0] rd_addr;
  logic                         s1_valid;
  logic                         wr_en;
  logic [NEURON_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;

  assign start_acc = Start && (state_q == ST_IDLE);
  assign last_rd   = rd_fire && (rd_idx_q == count_q - NEURON_ADDR_WIDTH'(1));

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (NeuronCount == '0 || Taumem == '0) state_d = ST_DONE;
          else                                   state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: if (last_rd) state_d = ST_DRAIN;
      // With stage 1 empty only the final write can remain, and it retires
      // in this very cycle, so the sweep is complete at this edge.
      ST_DRAIN: if (!s1_valid) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rd_fire = 1'b0;
    rd_addr = '0;
    if (state_q == ST_ISSUE && bus.RdGrant) begin
      rd_fire = 1'b1;
      rd_addr = rd_idx_q;
    end
  end

  // Sweep context: latched operands, read index, Busy/Done/Error flags
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q  <= '0;
      rd_idx_q <= '0;
      vrest_q  <= '0;
      taumem_q <= '0;
      deltat_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      // Done is one cycle behind the DONE state; Busy falls on the same edge.
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) busy_q <= 1'b0;
      if (start_acc) begin
        count_q  <= NeuronCount;
        vrest_q  <= Vrest;
        deltat_q <= DeltaT;
        taumem_q <= Taumem;
        rd_idx_q <= '0;
        busy_q   <= 1'b1;
        error_q  <= (Taumem == '0);
      end else if (rd_fire) begin
        rd_idx_q <= rd_idx_q + NEURON_ADDR_WIDTH'(1);
      end
    end
  end

  vmem_leak_scheduler_leak_write_pipe #(
    .DATA_WIDTH        (DATA_WIDTH),
    .NEURON_ADDR_WIDTH (NEURON_ADDR_WIDTH)
  ) u_pipe (
    .Clock       (Clock),
    .Reset       (Reset),
    .rd_fire     (rd_fire),
    .rd_addr     (rd_addr),
    .leak_result (bus.LeakVmemOut),
    .s1_valid    (s1_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  assign bus.VmemRdEn   = rd_fire;
  assign bus.VmemRdAddr = rd_addr;
  assign bus.LeakVrest  = vrest_q;
  assign bus.LeakDeltaT = deltat_q;
  assign bus.LeakTaumem = taumem_q;
  // Read data is forwarded only while a read result is actually on the bus,
  // so the datapath input is quiet (zero) outside valid cycles.
  assign bus.LeakVmemIn = s1_valid ? bus.VmemRdData : '0;
  assign bus.VmemWrEn   = wr_en;
  assign bus.VmemWrAddr = wr_addr;
  assign bus.VmemWrData = wr_data;

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Error = error_q;

endmodule

// File: doc/vmem_leak_scheduler.md
Name: vmem_leak_scheduler

Overview:
Timestep controller that sweeps every neuron's membrane potential through the combinational Vmem leak datapath once per timestep. On Start it reads each Vmem from the dual-port Vmem memory, presents the operands to the leak datapath, registers the result and writes it back. The read port is shared, so reads are gated by a grant. Sits between the timestep sequencer and the Vmem store, ahead of synaptic integration.

Parameters:
INTEGER_WIDTH, 32, integer bits of fixed-point Vmem
DATA_WIDTH_FRAC, 32, fractional bits of Vmem
DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, full Vmem width
DELTAT_WIDTH, 4, DeltaT width
NEURON_ADDR_WIDTH, 11, neuron index / memory address width

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  one-cycle pulse, begin sweep
NeuronCount  in  NEURON_ADDR_WIDTH  neurons to process; latched at Start
Vrest  in  INTEGER_WIDTH  signed; latched at Start
DeltaT  in  DELTAT_WIDTH  latched at Start
Taumem  in  INTEGER_WIDTH  signed; latched at Start
Busy  out  1  high from accepted Start until Done
Done  out  1  one-cycle pulse, sweep finished
Error  out  1  sticky; Taumem==0 at Start; cleared by next accepted Start
RdGrant  in  1  shared read port available this cycle
VmemRdEn  out  1  read request
VmemRdAddr  out  NEURON_ADDR_WIDTH  read address
VmemRdData  in  DATA_WIDTH  read data, valid exactly 1 cycle after VmemRdEn
LeakVrest, LeakDeltaT, LeakTaumem  out  as inputs  latched operands to leak datapath
LeakVmemIn  out  DATA_WIDTH  Vmem to datapath (= VmemRdData, pass-through)
LeakVmemOut  in  DATA_WIDTH  datapath result, combinational, same cycle
VmemWrEn  out  1  write strobe
VmemWrAddr  out  NEURON_ADDR_WIDTH  write address
VmemWrData  out  DATA_WIDTH  registered leak result

Behaviour:
- Reset (any time, incl. mid-sweep): state IDLE. All outputs 0. Counters and latched operands cleared. In-flight reads/writes are dropped.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: Start=1 latches NeuronCount, Vrest, DeltaT and Taumem, clears Error, sets Busy and loads RdIdx=0.
  - NeuronCount==0 or Taumem==0 -> DONE. Taumem==0 also sets Error. No memory access in either case.
  - Otherwise -> ISSUE.
- Start while Busy is ignored.
- ISSUE: each cycle with RdGrant=1, assert VmemRdEn with VmemRdAddr=RdIdx and increment RdIdx. Cycles with RdGrant=0 issue nothing; stall bubbles are allowed. After issuing RdIdx==NeuronCount-1 -> DRAIN.
- Pipeline, per neuron:
  - cycle t: read issued.
  - t+1: VmemRdData drives LeakVmemIn; LeakVmemOut is captured into VmemWrData, address carried along.
  - t+2: VmemWrEn=1.
  - Write latency is 2 cycles after the read. Writes preserve read order, one per read, and never merge.
- Stage valid bits follow VmemRdEn; bubbles propagate as VmemWrEn=0.
- DRAIN: wait until no read or write is in flight -> DONE.
- DONE: Done=1 for one cycle; Busy drops in the same cycle -> IDLE.
- Same-address read/write hazard cannot occur within a sweep because each address is touched once.
- Leak operands are constant for the whole sweep, even if the input ports change.
- NeuronCount is interpreted as unsigned. The maximum 2^NEURON_ADDR_WIDTH-1 processes addresses 0..max-1 with no wrap.
- Busy and Done are registered.

Decomposition:
- Shared package: state encoding, fixed-point width constants (INTEGER_WIDTH, DATA_WIDTH_FRAC, DELTAT_WIDTH), Vmem fixed-point typedef.
- One sub-module: leak_write_pipe, the 2-stage valid/address/data shift path between read and write. The FSM and issue counter stay in the top.
- The leak datapath itself is instantiated outside; the block only drives its operands.

Test Plan:
- NeuronCount=4, RdGrant=1 constant, Vrest=-65, DeltaT=4 (0.25), Taumem=10, Vmem[0..3]=-55.0 -> reads at cycles 1-4, writes at 3-6, each VmemWrData=-55.25 (Q32.32). Done at cycle 8 (Start in cycle 0).
- Same setup, RdGrant low on cycles 2 and 3 -> reads at 1, 4, 5, 6; writes 2 cycles after each read, in order; no write during bubbles.
- NeuronCount=0 -> Done pulse 2 cycles after Start, Error=0, zero VmemRdEn/VmemWrEn.
- Taumem=0, NeuronCount=8 -> Error=1, Done pulse, no memory access. A following valid Start clears Error.
- Reset asserted mid-ISSUE (after 3 of 8 reads) -> all outputs 0 asynchronously. After release, Start sweeps all 8 neurons from address 0.
- Start pulsed again while Busy, with different Vrest -> ignored. All writes use the original Vrest; exactly one Done.
